// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_pkg
// Description : Shared defaults and requester encoding for the register-file
//               writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;

    // Requester identity; also the encoding of the round-robin history flag.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_buffer
// Description : One-entry hold buffer for a writeback requester. Accepts a
//               new request while empty, or while its current entry is being
//               drained by the arbiter in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_buffer
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    // Room is available when empty or when the held entry leaves this cycle.
    assign o_ready  = !r_valid || i_grant;
    assign w_accept = i_valid && o_ready;

    // Load on accept; otherwise empty out once the arbiter takes the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_grant) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Merges ALU and memory-load writeback requests onto a single
//               registered register-file write port. Each requester has a
//               one-entry hold buffer; ties are broken round-robin with the
//               ALU winning the first tie after reset. Writes to register 0
//               are drained silently.
//               Optional macro RF_SCOREBOARD_EN enables the busy_mask
//               pending-write scoreboard; otherwise busy_mask is all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [2**ADDR_W-1:0] busy_mask
);

    logic              w_aluValid;
    logic [ADDR_W-1:0] w_aluAddr;
    logic [DATA_W-1:0] w_aluData;
    logic              w_memValid;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memData;

    logic              w_grantAlu;
    logic              w_grantMem;
    logic              w_anyGrant;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selData;
    logic              w_doWrite;

    req_e              r_lastGrant;
    logic              r_rfWe;
    logic [ADDR_W-1:0] r_rfWaddr;
    logic [DATA_W-1:0] r_rfWdata;

    rf_wb_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_aluBuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (alu_valid),
        .i_addr  (alu_addr),
        .i_data  (alu_data),
        .i_grant (w_grantAlu),
        .o_ready (alu_ready),
        .o_valid (w_aluValid),
        .o_addr  (w_aluAddr),
        .o_data  (w_aluData)
    );

    rf_wb_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_memBuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (mem_valid),
        .i_addr  (mem_addr),
        .i_data  (mem_data),
        .i_grant (w_grantMem),
        .o_ready (mem_ready),
        .o_valid (w_memValid),
        .o_addr  (w_memAddr),
        .o_data  (w_memData)
    );

    // A lone full buffer wins outright; on a tie the side not granted last wins.
    assign w_grantAlu = w_aluValid && (!w_memValid || (r_lastGrant == REQ_MEM));
    assign w_grantMem = w_memValid && (!w_aluValid || (r_lastGrant == REQ_ALU));
    assign w_anyGrant = w_grantAlu || w_grantMem;
    assign w_selAddr  = w_grantAlu ? w_aluAddr : w_memAddr;
    assign w_selData  = w_grantAlu ? w_aluData : w_memData;
    // Register 0 is hard-wired: its writes are consumed but never issued.
    assign w_doWrite  = w_anyGrant && (w_selAddr != '0);

    // Output write stage and round-robin history; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= REQ_MEM;
            r_rfWe      <= 1'b0;
            r_rfWaddr   <= '0;
            r_rfWdata   <= '0;
        end else begin
            r_rfWe <= w_doWrite;
            if (w_anyGrant) begin
                r_lastGrant <= w_grantAlu ? REQ_ALU : REQ_MEM;
            end
            if (w_doWrite) begin
                r_rfWaddr <= w_selAddr;
                r_rfWdata <= w_selData;
            end
        end
    end

    assign rf_we    = r_rfWe;
    assign rf_waddr = r_rfWaddr;
    assign rf_wdata = r_rfWdata;

`ifdef RF_SCOREBOARD_EN
    // A register is busy while either buffer or the live write stage targets it.
    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_busy
        if (i == 0) begin : g_reg0
            assign busy_mask[i] = 1'b0;
        end else begin : g_regN
            assign busy_mask[i] = (w_aluValid && (w_aluAddr == ADDR_W'(i))) ||
                                  (w_memValid && (w_memAddr == ADDR_W'(i))) ||
                                  (r_rfWe     && (r_rfWaddr == ADDR_W'(i)));
        end
    end
`else
    assign busy_mask = '0;
`endif

endmodule
`default_nettype wire
